// File: rtl/yolo_pkg.sv
// Shared constants and types for the YOLO conv weight-fetch path.
package yolo_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned FILTER_SIZE = 27;
  localparam int unsigned NUM_FILTERS = 8;
  localparam int unsigned SEL_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/weight_skid_buf.sv
// Two-entry weight FIFO between the ROM return path and the PE weight port.
module weight_skid_buf
  import yolo_pkg::*;
#(
  parameter int unsigned DATA_W = yolo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  // When full, a push can only coincide with a pop; the write lands in the
  // slot being vacated, so ordering is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/filter_fetch_ctrl.sv
// Streams the 27 weights of one selected filter from the weight ROM to the
// PE array, absorbing ROM latency and backpressure in a 2-entry buffer.
module filter_fetch_ctrl
  import yolo_pkg::*;
#(
  parameter int unsigned DATA_W      = yolo_pkg::DATA_W,
  parameter int unsigned ADDR_W      = yolo_pkg::ADDR_W,
  parameter int unsigned FILTER_SIZE = yolo_pkg::FILTER_SIZE,
  parameter int unsigned NUM_FILTERS = yolo_pkg::NUM_FILTERS,
  parameter int unsigned SEL_W       = yolo_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  filter_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last
);

  localparam int unsigned     CNT_W    = $clog2(FILTER_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FILTER_SIZE - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              rd_vld_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              rom_en_c;
  logic [ADDR_W-1:0] rom_addr_c;
  logic              sel_ok_c;
  logic              pop_c;
  logic [2:0]        fill_c;
  logic [1:0]        buf_count;
  logic [DATA_W-1:0] buf_head;

  weight_skid_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_vld_q),
    .push_data (rom_data),
    .pop       (pop_c),
    .count     (buf_count),
    .head_data (buf_head)
  );

  assign w_valid  = (buf_count != 2'd0);
  assign pop_c    = w_valid & w_ready;
  assign sel_ok_c = (32'(filter_sel) < NUM_FILTERS);
  // Buffer slots committed once this cycle's pop retires; a read issued now
  // lands after the current in-flight one, so it needs one free slot.
  assign fill_c   = 3'(buf_count) + 3'(rd_vld_q) - 3'(pop_c);

  // Next-state, counters and ROM issue
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = 1'b0;
    rom_en_c    = 1'b0;
    rom_addr_c  = '0;

    if (pop_c) begin
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (sel_ok_c) begin
            state_d     = FETCH;
            base_d      = ADDR_W'(32'(filter_sel) * FILTER_SIZE);
            issue_cnt_d = '0;
            beat_cnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (fill_c < 3'd2) begin
          rom_en_c    = 1'b1;
          rom_addr_c  = base_q + ADDR_W'(issue_cnt_q);
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop_c && (beat_cnt_q == LAST_IDX)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      rd_vld_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      rd_vld_q    <= rom_en_c;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rom_en   = rom_en_c;
  assign rom_addr = rom_addr_c;
  assign w_data   = w_valid ? buf_head : '0;
  assign w_last   = w_valid & (beat_cnt_q == LAST_IDX);

endmodule
